// File: rtl/fetch_stage_ss.sv
// fetch_stage_ss: superscalar fetch stage, 64-bit line requests to I-memory
// feeding a line-wide fetch queue that drains into the instruction buffer.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   if_stall            hold off new memory requests
//   redirect_valid/pc   squash queued and in-flight fetches, refetch at pc
//   proc2Imem_req/addr  line request, held until Imem2proc_gnt
//   Imem2proc_valid/data  in-order line responses
//   ib_ready            IB takes the head packet this cycle
//   fq_valid/inst/pc/npc  head packet, one slot per fetched instruction
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h00000013
`endif

module fetch_stage_ss #(
   parameter int FETCH_WIDTH     = 2,
   parameter int FQ_DEPTH        = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           if_stall,
   input  logic                           redirect_valid,
   input  logic [`XLEN-1:0]               redirect_pc,
   output logic                           proc2Imem_req,
   output logic [`XLEN-1:0]               proc2Imem_addr,
   input  logic                           Imem2proc_gnt,
   input  logic                           Imem2proc_valid,
   input  logic [63:0]                    Imem2proc_data,
   input  logic                           ib_ready,
   output logic [FETCH_WIDTH-1:0]         fq_valid,
   output logic [32*FETCH_WIDTH-1:0]      fq_inst,
   output logic [`XLEN*FETCH_WIDTH-1:0]   fq_pc,
   output logic [`XLEN*FETCH_WIDTH-1:0]   fq_npc
);

   localparam int W   = FETCH_WIDTH;
   localparam int XW  = `XLEN;
   localparam int QPW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int MPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int QCW = $clog2(FQ_DEPTH + 1);
   localparam int MCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW  = ((QCW > MCW) ? QCW : MCW) + 1;

   logic [XW-1:0]              fetch_pc;
   logic [XW-1:0]              next_pc;

   logic [XW-1:0]              meta_pc [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] meta_kill;
   logic [MPW-1:0]             meta_wp;
   logic [MPW-1:0]             meta_rp;
   logic [MCW-1:0]             meta_cnt;

   logic [W-1:0]               fq_v_mem  [FQ_DEPTH];
   logic [32*W-1:0]            fq_i_mem  [FQ_DEPTH];
   logic [XW-1:0]              fq_pc_mem [FQ_DEPTH];
   logic [QPW-1:0]             fq_wp;
   logic [QPW-1:0]             fq_rp;
   logic [QCW-1:0]             fq_cnt;

   logic                       issue;
   logic                       resp;
   logic                       fq_push;
   logic                       fq_pop;
   logic                       fq_nonempty;
   logic                       credit_ok;
   logic [XW-1:0]              head_pc;
   logic                       head_kill;
   logic [W-1:0]               ext_v;
   logic [32*W-1:0]            ext_i;
   logic [XW-1:0]              ext_base;

   function automatic logic [MPW-1:0] m_inc(input logic [MPW-1:0] p);
      return (p == MPW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
      return (p == QPW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Killed in-flight lines still hold a credit, so the FQ can
   // always absorb every response that is not dropped.
   assign credit_ok = (SW'(meta_cnt) + SW'(fq_cnt)) < SW'(FQ_DEPTH);

   assign proc2Imem_req = !reset && !if_stall && !redirect_valid
                       && (meta_cnt < MCW'(MAX_OUTSTANDING))
                       && credit_ok;
   assign proc2Imem_addr = fetch_pc & ~XW'(7);

   assign issue     = proc2Imem_req && Imem2proc_gnt;
   assign resp      = Imem2proc_valid && (meta_cnt != '0);
   assign head_pc   = meta_pc[meta_rp];
   assign head_kill = meta_kill[meta_rp];
   assign fq_push   = resp && !head_kill && !redirect_valid;

   assign fq_nonempty = (fq_cnt != '0);
   assign fq_valid    = fq_nonempty ? fq_v_mem[fq_rp] : '0;
   assign fq_pop      = ib_ready && (|fq_valid);

   generate
      if (W == 2) begin : g_w2
         // A fetch entering mid-line skips the lower word.
         assign next_pc  = (fetch_pc & ~XW'(7)) + XW'(8);
         assign ext_v    = {1'b1, ~head_pc[2]};
         assign ext_i    = Imem2proc_data;
         assign ext_base = head_pc & ~XW'(7);
      end else begin : g_w1
         assign next_pc  = fetch_pc + XW'(4);
         assign ext_v    = 1'b1;
         assign ext_i    = head_pc[2] ? Imem2proc_data[63:32]
                                      : Imem2proc_data[31:0];
         assign ext_base = head_pc;
      end
   endgenerate

   for (genvar i = 0; i < W; i++) begin : g_slot
      assign fq_inst[32*i +: 32] = fq_valid[i]
                                 ? fq_i_mem[fq_rp][32*i +: 32]
                                 : `NOP;
      assign fq_pc[XW*i +: XW]   = fq_nonempty
                                 ? fq_pc_mem[fq_rp] + XW'(4*i)
                                 : '0;
      assign fq_npc[XW*i +: XW]  = fq_nonempty
                                 ? fq_pc_mem[fq_rp] + XW'(4*i + 4)
                                 : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc  <= '0;
         meta_kill <= '0;
         meta_wp   <= '0;
         meta_rp   <= '0;
         meta_cnt  <= '0;
         fq_wp     <= '0;
         fq_rp     <= '0;
         fq_cnt    <= '0;
      end else begin
         if (redirect_valid)
            fetch_pc <= redirect_pc;
         else if (issue)
            fetch_pc <= next_pc;

         if (issue) begin
            meta_pc[meta_wp] <= fetch_pc;
            meta_wp          <= m_inc(meta_wp);
         end
         // Marking free slots too is harmless: a push clears its own bit.
         if (redirect_valid)
            meta_kill <= '1;
         else if (issue)
            meta_kill[meta_wp] <= 1'b0;
         if (resp)
            meta_rp <= m_inc(meta_rp);
         meta_cnt <= meta_cnt + MCW'(issue) - MCW'(resp);

         if (redirect_valid) begin
            fq_wp  <= '0;
            fq_rp  <= '0;
            fq_cnt <= '0;
         end else begin
            if (fq_push) begin
               fq_v_mem[fq_wp]  <= ext_v;
               fq_i_mem[fq_wp]  <= ext_i;
               fq_pc_mem[fq_wp] <= ext_base;
               fq_wp            <= q_inc(fq_wp);
            end
            if (fq_pop)
               fq_rp <= q_inc(fq_rp);
            fq_cnt <= fq_cnt + QCW'(fq_push) - QCW'(fq_pop);
         end
      end
   end

   a_resp_has_meta: assert property (
      @(posedge clock) disable iff (reset)
      Imem2proc_valid |-> meta_cnt != '0);

endmodule

// File: tb/tb_fetch_stage_ss.sv
// tb_fetch_stage_ss: directed scoreboard bench for fetch_stage_ss,
// a W=2 instance with a latency-programmable memory and a W=1 instance.
module tb_fetch_stage_ss;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset = 1'b1;
   logic        if_stall = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req;
   logic [31:0] addr;
   logic        gnt = 1'b1;
   logic        mvalid = 1'b0;
   logic [63:0] mdata = '0;
   logic        ib_ready = 1'b1;
   logic [1:0]  fq_valid;
   logic [63:0] fq_inst;
   logic [63:0] fq_pc;
   logic [63:0] fq_npc;

   logic        reset1 = 1'b1;
   logic        if_stall1 = 1'b1;
   logic        req1;
   logic [31:0] addr1;
   logic        mvalid1 = 1'b0;
   logic [63:0] mdata1 = '0;
   logic        fq_valid1;
   logic [31:0] fq_inst1;
   logic [31:0] fq_pc1;
   logic [31:0] fq_npc1;

   fetch_stage_ss #(.FETCH_WIDTH(2), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)) u2 (
      .clock(clock), .reset(reset), .if_stall(if_stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .proc2Imem_req(req), .proc2Imem_addr(addr),
      .Imem2proc_gnt(gnt), .Imem2proc_valid(mvalid),
      .Imem2proc_data(mdata), .ib_ready(ib_ready),
      .fq_valid(fq_valid), .fq_inst(fq_inst),
      .fq_pc(fq_pc), .fq_npc(fq_npc));

   fetch_stage_ss #(.FETCH_WIDTH(1), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)) u1 (
      .clock(clock), .reset(reset1), .if_stall(if_stall1),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .proc2Imem_req(req1), .proc2Imem_addr(addr1),
      .Imem2proc_gnt(1'b1), .Imem2proc_valid(mvalid1),
      .Imem2proc_data(mdata1), .ib_ready(1'b1),
      .fq_valid(fq_valid1), .fq_inst(fq_inst1),
      .fq_pc(fq_pc1), .fq_npc(fq_npc1));

   typedef struct {
      logic [1:0]  v;
      logic [63:0] inst;
      logic [63:0] pc;
      logic [63:0] npc;
   } pkt_t;

   typedef struct {
      logic [31:0] a;
      int          due;
   } mreq_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   pkt_t        exp_q[$];
   logic [31:0] exp_addr[$];
   mreq_t       mq[$];
   int          cyc = 0;
   int          mem_lat = 1;
   int          grants = 0;
   int          budget = 0;
   bit          gnt_en = 1'b1;

   pkt_t        exp1_q[$];
   logic [31:0] exp_addr1[$];
   int          grants1 = 0;
   int          budget1 = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   function automatic logic [63:0] line(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'h7;
      return {word(b + 32'd4), word(b)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic expect2(input logic [31:0] p);
      pkt_t k;
      logic [31:0] b;
      b      = p & ~32'h7;
      k.v    = {1'b1, ~p[2]};
      k.inst = {word(b + 32'd4), p[2] ? NOP : word(b)};
      k.pc   = {b + 32'd4, b};
      k.npc  = {b + 32'd8, b + 32'd4};
      exp_q.push_back(k);
      exp_addr.push_back(b);
   endtask

   task automatic expect1(input logic [31:0] p);
      pkt_t k;
      k.v    = 2'b01;
      k.inst = {32'h0, word(p)};
      k.pc   = {32'h0, p};
      k.npc  = {32'h0, p + 32'd4};
      exp1_q.push_back(k);
      exp_addr1.push_back(p & ~32'h7);
   endtask

   // W=2 memory: in-order responses after mem_lat cycles.
   logic        s_req, s_gnt, s_v, s_rst;
   logic [31:0] s_addr;
   always begin
      @(posedge clock);
      s_req = req; s_addr = addr; s_gnt = gnt;
      s_v = mvalid; s_rst = reset;
      if (s_rst) begin
         mq.delete();
      end else begin
         if (s_v && mq.size() != 0) void'(mq.pop_front());
         if (s_req && s_gnt) begin
            if (exp_addr.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_req: got addr %h, none expected", s_addr);
            end else begin
               chk("req_addr", {32'h0, s_addr}, {32'h0, exp_addr.pop_front()});
            end
            mq.push_back('{a: s_addr, due: cyc + mem_lat});
            grants++;
         end
      end
      #1;
      cyc++;
      gnt = gnt_en;
      if_stall = (grants >= budget);
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         mvalid = 1'b1; mdata = line(mq[0].a);
      end else begin
         mvalid = 1'b0; mdata = '0;
      end
   end

   // W=1 memory: always granted, one-cycle latency.
   logic        s1_req;
   logic [31:0] s1_addr;
   always begin
      @(posedge clock);
      s1_req = req1 && !reset1; s1_addr = addr1;
      if (s1_req) begin
         if (exp_addr1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_req_w1: got addr %h, none expected", s1_addr);
         end else begin
            chk("req_addr_w1", {32'h0, s1_addr}, {32'h0, exp_addr1.pop_front()});
         end
         grants1++;
      end
      #1;
      if_stall1 = (grants1 >= budget1);
      mvalid1 = s1_req;
      mdata1 = s1_req ? line(s1_addr) : '0;
   end

   // Monitors: a packet is delivered on ib_ready & any valid slot.
   always @(negedge clock) begin
      pkt_t e;
      if (!reset && ib_ready && (|fq_valid)) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexp_pkt: pc %h valid %b", fq_pc, fq_valid);
         end else begin
            e = exp_q.pop_front();
            chk("pkt_valid", {62'h0, fq_valid}, {62'h0, e.v});
            chk("pkt_inst", fq_inst, e.inst);
            chk("pkt_pc", fq_pc, e.pc);
            chk("pkt_npc", fq_npc, e.npc);
         end
      end
   end

   always @(negedge clock) begin
      pkt_t e;
      if (!reset1 && fq_valid1) begin
         if (exp1_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexp_pkt_w1: pc %h", fq_pc1);
         end else begin
            e = exp1_q.pop_front();
            chk("w1_inst", {32'h0, fq_inst1}, e.inst);
            chk("w1_pc", {32'h0, fq_pc1}, e.pc);
            chk("w1_npc", {32'h0, fq_npc1}, e.npc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic wait_grants(input int target, input string nm);
      int t;
      t = 0;
      while (grants < target && t < 100) begin tick(1); t++; end
      if (grants < target) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: grants %0d want %0d", nm, grants, target);
      end
   endtask

   task automatic wait_drain(input string nm);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || mq.size() != 0 || grants < budget)
             && t < 300) begin
         tick(1); t++;
      end
      if (exp_q.size() != 0 || mq.size() != 0 || grants < budget) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: drain timeout, %0d packets left", nm, exp_q.size());
      end
      tick(2);
   endtask

   initial begin
      int g0;
      int t;
      tick(2);
      @(negedge clock);
      chk("rst_req", {63'h0, req}, 64'h0);
      chk("rst_valid", {62'h0, fq_valid}, 64'h0);
      chk("rst_inst", fq_inst, {NOP, NOP});
      chk("rst_pc", fq_pc, 64'h0);
      chk("rst_npc", fq_npc, 64'h0);

      // Sequential lines from reset.
      tick(1);
      budget = 3;
      expect2(32'h0); expect2(32'h8); expect2(32'h10);
      tick(1);
      reset = 1'b0;
      @(negedge clock);
      chk("t1_valid_c0", {62'h0, fq_valid}, 64'h0);
      @(negedge clock);
      chk("t1_valid_c1", {62'h0, fq_valid}, 64'h0);
      @(negedge clock);
      chk("t1_valid_c2", {62'h0, fq_valid}, 64'h3);
      tick(0);
      wait_drain("t1");

      // Redirect into the upper half of a line.
      redirect_valid = 1'b1; redirect_pc = 32'h104;
      budget = grants + 3;
      expect2(32'h104); expect2(32'h108); expect2(32'h110);
      @(negedge clock);
      chk("t2_redir_req", {63'h0, req}, 64'h0);
      tick(1);
      redirect_valid = 1'b0;
      wait_drain("t2");

      // Slow memory, redirect while two lines are in flight.
      mem_lat = 5;
      budget = grants + 2;
      exp_addr.push_back(32'h118); exp_addr.push_back(32'h120);
      wait_grants(budget, "t4_grants");
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      budget = grants + 2;
      expect2(32'h200); expect2(32'h208);
      tick(1);
      redirect_valid = 1'b0;
      wait_drain("t4");
      mem_lat = 1;

      // IB back-pressure fills the queue exactly.
      ib_ready = 1'b0;
      g0 = grants;
      budget = grants + 8;
      for (int k = 0; k < 8; k++) expect2(32'h210 + 32'(8 * k));
      tick(10);
      @(negedge clock);
      chk("t3_req_blocked", {63'h0, req}, 64'h0);
      chk("t3_lines_enq", 64'(grants - g0), 64'd4);
      chk("t3_head_pc", fq_pc, {32'h214, 32'h210});
      tick(1);
      ib_ready = 1'b1;
      wait_drain("t3");

      // Withheld grant, then a redirect abandons the pending request.
      gnt_en = 1'b0;
      budget = grants + 1;
      tick(1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("t5_wait_req", {63'h0, req}, 64'h1);
         chk("t5_wait_addr", {32'h0, addr}, 64'h250);
         tick(1);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      expect2(32'h300);
      @(negedge clock);
      chk("t5_redir_req", {63'h0, req}, 64'h0);
      tick(1);
      redirect_valid = 1'b0;
      @(negedge clock);
      chk("t5_new_req", {63'h0, req}, 64'h1);
      chk("t5_new_addr", {32'h0, addr}, 64'h300);
      tick(1);
      gnt_en = 1'b1;
      wait_drain("t5");

      // Single-issue instance.
      budget1 = 4;
      expect1(32'h0); expect1(32'h4); expect1(32'h8); expect1(32'hC);
      tick(1);
      reset1 = 1'b0;
      t = 0;
      while ((exp1_q.size() != 0 || grants1 < budget1) && t < 100) begin
         tick(1); t++;
      end
      if (exp1_q.size() != 0 || grants1 < budget1) begin
         n_cmp++; n_bad++;
         $display("FAIL t6: drain timeout, %0d packets left", exp1_q.size());
      end
      tick(3);

      chk("left_pkts", 64'(exp_q.size() + exp1_q.size()), 64'h0);
      chk("left_addrs", 64'(exp_addr.size() + exp_addr1.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
